// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Shared types and constants for the Mode 5 countdown timer:
//            state encoding, HH:MM:SS field widths and limits, Set_Field
//            codes, and the potentiometer-to-field scaling helper.
// Revision : 1.0  initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_RUN      = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_DONE     = 3'd6
    } timer_state_t;

    localparam int c_HOUR_W   = 5;
    localparam int c_MINSEC_W = 6;

    localparam logic [c_HOUR_W-1:0]   MAX_HOUR   = 5'd23;
    localparam logic [c_MINSEC_W-1:0] MAX_MINSEC = 6'd59;

    localparam logic [1:0] c_FIELD_NONE = 2'd0;
    localparam logic [1:0] c_FIELD_HOUR = 2'd1;
    localparam logic [1:0] c_FIELD_MIN  = 2'd2;
    localparam logic [1:0] c_FIELD_SEC  = 2'd3;

    // Maps the 10-bit pot reading onto 0..range-1 as (pot*range)>>10.
    // 1023*60 = 61380 still fits the 16-bit product.
    function automatic logic [5:0] scale_pot(input logic [9:0] pot,
                                             input logic [5:0] range);
        return 6'((16'(pot) * 16'(range)) >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hms_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : hms_down_counter
// Purpose  : HH:MM:SS register with parallel load and a saturating
//            one-second decrement (sec borrows from min, min from hour).
// Ports    : clk, rst_n (sync, active low)
//            load / load_hour / load_minute / load_second : parallel load
//            dec  : decrement one second (ignored while hold is high)
//            hold : freeze the count
//            hour / minute / second : current count
//            is_zero : count is 00:00:00, or this cycle's decrement from
//                      00:00:01 lands on zero
// Revision : 1.0  initial release
// ============================================================================
module hms_down_counter
    import timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  dec,
    input  logic                  hold,
    input  logic [c_HOUR_W-1:0]   load_hour,
    input  logic [c_MINSEC_W-1:0] load_minute,
    input  logic [c_MINSEC_W-1:0] load_second,
    output logic [c_HOUR_W-1:0]   hour,
    output logic [c_MINSEC_W-1:0] minute,
    output logic [c_MINSEC_W-1:0] second,
    output logic                  is_zero
);

    logic [c_HOUR_W-1:0]   r_hour;
    logic [c_MINSEC_W-1:0] r_min;
    logic [c_MINSEC_W-1:0] r_sec;
    logic                  w_at_zero;
    logic                  w_at_one;
    logic                  w_do_dec;

    assign w_at_zero = (r_hour == '0) && (r_min == '0) && (r_sec == '0);
    assign w_at_one  = (r_hour == '0) && (r_min == '0) && (r_sec == 6'd1);
    assign w_do_dec  = dec && !hold;

    // Lets the controller enter DONE on the same edge the last second expires.
    assign is_zero = w_at_zero || (w_do_dec && w_at_one);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
        end else if (load) begin
            r_hour <= (load_hour > MAX_HOUR) ? MAX_HOUR : load_hour;
            r_min  <= (load_minute > MAX_MINSEC) ? MAX_MINSEC : load_minute;
            r_sec  <= (load_second > MAX_MINSEC) ? MAX_MINSEC : load_second;
        end else if (w_do_dec && !w_at_zero) begin
            // Not at zero, so when both sec and min are 0 the hour is non-zero.
            if (r_sec != '0) begin
                r_sec <= r_sec - 6'd1;
            end else begin
                r_sec <= MAX_MINSEC;
                if (r_min != '0) begin
                    r_min <= r_min - 6'd1;
                end else begin
                    r_min  <= MAX_MINSEC;
                    r_hour <= r_hour - 5'd1;
                end
            end
        end
    end

    assign hour   = r_hour;
    assign minute = r_min;
    assign second = r_sec;

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_ctrl
// Purpose  : Mode 5 countdown-timer sequencer: HH:MM:SS preset entry from the
//            potentiometer, start/pause/clear, 1 Hz prescaler, DONE flag.
// Ports    : Clock_50MHz, RESET_N (sync, active low)
//            Cmd_Short / Cmd_Long : qualified single-cycle button pulses
//            PotentiometerValue   : field value source while setting
//            Hour / Min / Sec     : preset while setting, live count otherwise
//            Set_Field            : 0 none, 1 hour, 2 min, 3 sec
//            Running / Done_Sig   : high in RUN / DONE
// Config   : TIMER_AUTO_SILENCE_EN - DONE clears itself after ALARM_SEC ticks
// Revision : 1.0  initial release
// ============================================================================
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int ALARM_SEC = 30
) (
    input  logic                  Clock_50MHz,
    input  logic                  RESET_N,
    input  logic                  Cmd_Short,
    input  logic                  Cmd_Long,
    input  logic [9:0]            PotentiometerValue,
    output logic [c_HOUR_W-1:0]   Hour,
    output logic [c_MINSEC_W-1:0] Min,
    output logic [c_MINSEC_W-1:0] Sec,
    output logic [1:0]            Set_Field,
    output logic                  Running,
    output logic                  Done_Sig
);

    localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);

    timer_state_t          r_state;
    logic [c_HOUR_W-1:0]   r_pre_h,  r_shd_h;
    logic [c_MINSEC_W-1:0] r_pre_m,  r_shd_m;
    logic [c_MINSEC_W-1:0] r_pre_s,  r_shd_s;
    logic [c_PRESC_W-1:0]  r_presc;

    logic                  w_tick;
    logic                  w_silenced;
    logic [c_HOUR_W-1:0]   w_pot_hour;
    logic [c_MINSEC_W-1:0] w_pot_minsec;
    logic                  w_load, w_dec, w_hold, w_is_zero;
    logic [c_HOUR_W-1:0]   w_load_h, w_cnt_h;
    logic [c_MINSEC_W-1:0] w_load_m, w_cnt_m;
    logic [c_MINSEC_W-1:0] w_load_s, w_cnt_s;

    assign w_tick       = (r_presc == c_TICK_LAST);
    assign w_pot_hour   = 5'(scale_pot(PotentiometerValue, 6'd24));
    assign w_pot_minsec = scale_pot(PotentiometerValue, 6'd60);

`ifdef TIMER_AUTO_SILENCE_EN
    localparam logic [4:0] c_SILENCE_LAST = 5'(ALARM_SEC - 1);
    logic [4:0] r_silence;
    assign w_silenced = (r_state == ST_DONE) && w_tick && (r_silence == c_SILENCE_LAST);
`else
    assign w_silenced = 1'b0;
`endif

    // Counter control: Long always wins, and every exit to IDLE reloads the
    // count from the preset (or from the shadow when a setting is aborted).
    always_comb begin
        w_load   = 1'b0;
        w_dec    = 1'b0;
        w_load_h = r_pre_h;
        w_load_m = r_pre_m;
        w_load_s = r_pre_s;
        unique case (r_state)
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                if (Cmd_Long) begin
                    w_load   = 1'b1;
                    w_load_h = r_shd_h;
                    w_load_m = r_shd_m;
                    w_load_s = r_shd_s;
                end else if (Cmd_Short && (r_state == ST_SET_SEC)) begin
                    w_load   = 1'b1;
                    w_load_s = w_pot_minsec;
                end
            end
            ST_RUN: begin
                if (Cmd_Long) w_load = 1'b1;
                else          w_dec  = w_tick;
            end
            ST_PAUSE: w_load = Cmd_Long;
            ST_DONE:  w_load = Cmd_Long || Cmd_Short || w_silenced;
            default:  ;
        endcase
    end

    assign w_hold = (r_state != ST_RUN);

    hms_down_counter u_count (
        .clk         (Clock_50MHz),
        .rst_n       (RESET_N),
        .load        (w_load),
        .dec         (w_dec),
        .hold        (w_hold),
        .load_hour   (w_load_h),
        .load_minute (w_load_m),
        .load_second (w_load_s),
        .hour        (w_cnt_h),
        .minute      (w_cnt_m),
        .second      (w_cnt_s),
        .is_zero     (w_is_zero)
    );

    always_ff @(posedge Clock_50MHz) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_pre_h <= '0;
            r_pre_m <= '0;
            r_pre_s <= '0;
            r_shd_h <= '0;
            r_shd_m <= '0;
            r_shd_s <= '0;
            r_presc <= '0;
`ifdef TIMER_AUTO_SILENCE_EN
            r_silence <= '0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (Cmd_Long) begin
                        r_shd_h <= r_pre_h;
                        r_shd_m <= r_pre_m;
                        r_shd_s <= r_pre_s;
                        r_state <= ST_SET_HOUR;
                    end else if (Cmd_Short && !w_is_zero) begin
                        r_presc <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                    if (Cmd_Long) begin
                        r_pre_h <= r_shd_h;
                        r_pre_m <= r_shd_m;
                        r_pre_s <= r_shd_s;
                        r_state <= ST_IDLE;
                    end else begin
                        // The edited field follows the pot every cycle; Short
                        // simply moves on, keeping the value just captured.
                        if (r_state == ST_SET_HOUR) r_pre_h <= w_pot_hour;
                        if (r_state == ST_SET_MIN)  r_pre_m <= w_pot_minsec;
                        if (r_state == ST_SET_SEC)  r_pre_s <= w_pot_minsec;
                        if (Cmd_Short) begin
                            if (r_state == ST_SET_HOUR)     r_state <= ST_SET_MIN;
                            else if (r_state == ST_SET_MIN) r_state <= ST_SET_SEC;
                            else                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    if (Cmd_Long) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        // A tick landing on zero beats a simultaneous pause.
                        if (w_tick && w_is_zero) begin
                            r_state <= ST_DONE;
`ifdef TIMER_AUTO_SILENCE_EN
                            r_silence <= '0;
`endif
                        end else if (Cmd_Short) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (Cmd_Long)       r_state <= ST_IDLE;
                    else if (Cmd_Short) r_state <= ST_RUN;
                end
                ST_DONE: begin
                    if (Cmd_Long || Cmd_Short) begin
                        r_state <= ST_IDLE;
                    end
`ifdef TIMER_AUTO_SILENCE_EN
                    else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_silenced)  r_state   <= ST_IDLE;
                        else if (w_tick) r_silence <= r_silence + 5'd1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        Hour      = w_cnt_h;
        Min       = w_cnt_m;
        Sec       = w_cnt_s;
        Set_Field = c_FIELD_NONE;
        unique case (r_state)
            ST_SET_HOUR: Set_Field = c_FIELD_HOUR;
            ST_SET_MIN:  Set_Field = c_FIELD_MIN;
            ST_SET_SEC:  Set_Field = c_FIELD_SEC;
            default:     ;
        endcase
        if (Set_Field != c_FIELD_NONE) begin
            Hour = r_pre_h;
            Min  = r_pre_m;
            Sec  = r_pre_s;
        end
    end

    assign Running  = (r_state == ST_RUN);
    assign Done_Sig = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_ctrl
// Purpose  : Self-checking bench for countdown_timer_ctrl with TICK_DIV=10,
//            ALARM_SEC=3. A seconds-based reference model is compared with
//            every DUT output each cycle; literal checks pin key moments.
// Config   : TIMER_AUTO_SILENCE_EN selects the DONE expectation.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_countdown_timer_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int ALARM_SEC = 3;

    localparam int M_IDLE = 0, M_SETH = 1, M_SETM = 2, M_SETS = 3;
    localparam int M_RUN = 4, M_PAUSE = 5, M_DONE = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_short = 1'b0;
    logic       cmd_long = 1'b0;
    logic [9:0] pot = '0;
    logic [4:0] hour;
    logic [5:0] min_o, sec_o;
    logic [1:0] set_field;
    logic       running, done_sig;

    int checks = 0;
    int errors = 0;

    // Reference model: count held as total seconds.
    int m_mode = M_IDLE;
    int m_secs = 0;
    int m_phase = 0;
    int m_silence = 0;
    int m_pre[3] = '{0, 0, 0};
    int m_shadow[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    countdown_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_SEC(ALARM_SEC)) dut (
        .Clock_50MHz        (clk),
        .RESET_N            (rst_n),
        .Cmd_Short          (cmd_short),
        .Cmd_Long           (cmd_long),
        .PotentiometerValue (pot),
        .Hour               (hour),
        .Min                (min_o),
        .Sec                (sec_o),
        .Set_Field          (set_field),
        .Running            (running),
        .Done_Sig           (done_sig)
    );

    function automatic int preset_secs();
        return m_pre[0] * 3600 + m_pre[1] * 60 + m_pre[2];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit tick;
        if (!rst_n) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_silence = 0;
            m_pre = '{0, 0, 0}; m_shadow = '{0, 0, 0};
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (cmd_long) begin
                        m_shadow = m_pre; m_mode = M_SETH;
                    end else if (cmd_short && m_secs != 0) begin
                        m_mode = M_RUN; m_phase = 0;
                    end
                end
                M_SETH, M_SETM, M_SETS: begin
                    if (cmd_long) begin
                        m_pre = m_shadow; m_secs = preset_secs(); m_mode = M_IDLE;
                    end else begin
                        m_pre[m_mode-1] = (int'(pot) * ((m_mode == M_SETH) ? 24 : 60)) / 1024;
                        if (cmd_short) begin
                            if (m_mode == M_SETS) begin
                                m_secs = preset_secs(); m_mode = M_IDLE;
                            end else begin
                                m_mode = m_mode + 1;
                            end
                        end
                    end
                end
                M_RUN: begin
                    if (cmd_long) begin
                        m_secs = preset_secs(); m_mode = M_IDLE;
                    end else begin
                        tick = (m_phase == TICK_DIV - 1);
                        m_phase = tick ? 0 : m_phase + 1;
                        if (tick) m_secs = m_secs - 1;
                        if (tick && m_secs == 0) begin
                            m_mode = M_DONE; m_silence = 0;
                        end else if (cmd_short) begin
                            m_mode = M_PAUSE;
                        end
                    end
                end
                M_PAUSE: begin
                    if (cmd_long) begin
                        m_secs = preset_secs(); m_mode = M_IDLE;
                    end else if (cmd_short) begin
                        m_mode = M_RUN;
                    end
                end
                M_DONE: begin
                    if (cmd_long || cmd_short) begin
                        m_secs = preset_secs(); m_mode = M_IDLE;
                    end
`ifdef TIMER_AUTO_SILENCE_EN
                    else begin
                        tick = (m_phase == TICK_DIV - 1);
                        m_phase = tick ? 0 : m_phase + 1;
                        if (tick) m_silence = m_silence + 1;
                        if (m_silence == ALARM_SEC) begin
                            m_secs = preset_secs(); m_mode = M_IDLE;
                        end
                    end
`endif
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // One clock: drive inputs at the falling edge, step the model, then
    // compare every output at the next falling edge.
    task automatic cycle(input bit s, input bit l);
        bit setting;
        cmd_short = s;
        cmd_long  = l;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cmd_short = 1'b0;
        cmd_long  = 1'b0;
        setting = (m_mode >= M_SETH) && (m_mode <= M_SETS);
        check("model_hour", int'(hour),  setting ? m_pre[0] : m_secs / 3600);
        check("model_min",  int'(min_o), setting ? m_pre[1] : (m_secs / 60) % 60);
        check("model_sec",  int'(sec_o), setting ? m_pre[2] : m_secs % 60);
        check("model_set_field", int'(set_field), setting ? m_mode : 0);
        check("model_running",   int'(running),  (m_mode == M_RUN) ? 1 : 0);
        check("model_done",      int'(done_sig), (m_mode == M_DONE) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic set_preset(input int hp, input int mp, input int sp);
        cycle(1'b0, 1'b1);
        pot = 10'(hp); cycle(1'b1, 1'b0);
        pot = 10'(mp); cycle(1'b1, 1'b0);
        pot = 10'(sp); cycle(1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        check("reset_hour", int'(hour), 0);
        check("reset_sec", int'(sec_o), 0);
        check("reset_flags", int'({set_field, running, done_sig}), 0);
        rst_n = 1'b1;

        // Short with a zero count stays in IDLE.
        cycle(1'b1, 1'b0);
        check("zero_start_running", int'(running), 0);

        // Field setting sequence: 12:00:01.
        cycle(1'b0, 1'b1);
        check("set_field_hour", int'(set_field), 1);
        pot = 10'd512; cycle(1'b1, 1'b0);
        check("set_field_min", int'(set_field), 2);
        check("set_hour_12", int'(hour), 12);
        pot = 10'd0; cycle(1'b1, 1'b0);
        check("set_field_sec", int'(set_field), 3);
        pot = 10'd20; cycle(1'b1, 1'b0);
        check("set_field_none", int'(set_field), 0);
        check("set_result", int'({hour, min_o, sec_o}), int'({5'd12, 6'd0, 6'd1}));

        // Borrow chain from 01:00:00.
        set_preset(43, 0, 0);
        cycle(1'b1, 1'b0);
        check("borrow_running", int'(running), 1);
        idle(9);
        check("borrow_before", int'({hour, min_o, sec_o}), int'({5'd1, 6'd0, 6'd0}));
        idle(1);
        check("borrow_after", int'({hour, min_o, sec_o}), int'({5'd0, 6'd59, 6'd59}));
        check("borrow_running2", int'(running), 1);
        cycle(1'b0, 1'b1);

        // Expiry from 00:00:02: DONE exactly 20 cycles after start.
        set_preset(0, 0, 35);
        cycle(1'b1, 1'b0);
        idle(19);
        check("expiry_not_yet", int'(done_sig), 0);
        idle(1);
        check("expiry_done", int'(done_sig), 1);
        check("expiry_count", int'({hour, min_o, sec_o}), 0);
        cycle(1'b1, 1'b0);
        check("expiry_cleared", int'({done_sig, sec_o}), 2);

        // Pause / resume from 00:00:05 keeps the partial second.
        set_preset(0, 0, 86);
        cycle(1'b1, 1'b0);
        idle(13);
        check("pause_pre_sec", int'(sec_o), 4);
        cycle(1'b1, 1'b0);
        check("pause_running", int'(running), 0);
        idle(50);
        check("pause_held", int'(sec_o), 4);
        cycle(1'b1, 1'b0);
        idle(5);
        check("resume_5", int'(sec_o), 4);
        idle(1);
        check("resume_6", int'(sec_o), 3);
        cycle(1'b0, 1'b1);

        // Short+Long together in RUN: Long wins.
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1);
        check("both_running", int'(running), 0);
        check("both_sec", int'(sec_o), 5);

        // Long in SET_MIN restores old preset.
        cycle(1'b0, 1'b1);
        pot = 10'd512; cycle(1'b1, 1'b0);
        pot = 10'd200; cycle(1'b0, 1'b0);
        check("abort_min_live", int'(min_o), 11);
        cycle(1'b0, 1'b1);
        check("abort_restored", int'({hour, min_o, sec_o, set_field}), int'({5'd0, 6'd0, 6'd5, 2'd0}));

        // DONE persistence / auto-silence.
        set_preset(0, 0, 35);
        cycle(1'b1, 1'b0);
        idle(20);
        check("silence_done", int'(done_sig), 1);
`ifdef TIMER_AUTO_SILENCE_EN
        idle(29);
        check("silence_still", int'(done_sig), 1);
        idle(1);
        check("silence_cleared", int'({done_sig, sec_o}), 2);
`else
        idle(1000);
        check("persist_done", int'(done_sig), 1);
        cycle(1'b1, 1'b0);
        check("persist_cleared", int'(done_sig), 0);
`endif

        // Reset mid-RUN.
        cycle(1'b1, 1'b0);
        idle(5);
        rst_n = 1'b0;
        cycle(1'b0, 1'b0);
        check("midrun_reset", int'({hour, min_o, sec_o, set_field, running, done_sig}), 0);
        rst_n = 1'b1;
        idle(12);
        check("midrun_no_tick", int'({running, sec_o}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
